md_unit: RTL and testbench

- Multi-cycle multiply/divide unit sitting beside the ALU in the EX stage. It consumes the same two 32-bit operands A and B and holds the HI/LO result registers.
- Models fixed MIPS-style latency with a Busy flag. The hazard unit uses Busy to stall dependent mfhi/mflo and any further md ops.
- Also services mthi/mtlo writes.

---
 rtl/md_defs.sv | 27 ++
 rtl/md_calc.sv | 24 ++
 rtl/md_unit.sv | 50 +++++
 tb/tb_md_unit.sv | 132 +++++++++++++
 4 files changed

// File: rtl/md_defs.sv
// md_defs: shared MDOp/ALUOp encodings and default multiply/divide latencies
package md_defs;
  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/md_calc.sv
// md_calc: combinational mult/multu/div/divu on magnitudes (a_i, b_i, op_i {div,unsigned} -> hi_o, lo_o), with div0 and overflow handling
module md_calc (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [1:0]  op_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  logic sgn, neg;
  logic [31:0] ma, mb, q, r;
  logic [63:0] p;
  always_comb begin
    sgn = !op_i[0];
    neg = sgn && (a_i[31] ^ b_i[31]);
    ma = (sgn && a_i[31]) ? -a_i : a_i;
    mb = (sgn && b_i[31]) ? -b_i : b_i;
    p = {32'd0, ma} * {32'd0, mb};
    q = (mb == 32'd0) ? 32'd0 : ma / mb;
    r = (mb == 32'd0) ? 32'd0 : ma % mb;
    {hi_o, lo_o} = op_i[1] ? ((b_i == 32'd0) ? {a_i, 32'hFFFF_FFFF}
                                             : {(sgn && a_i[31]) ? -r : r, neg ? -q : q})
                           : (neg ? -p : p);
  end
endmodule

// File: rtl/md_unit.sv
// md_unit: fixed-latency HI/LO multiply/divide unit (clk, reset, A, B, MDOp, Start -> Busy, HI, LO)
module md_unit
  import md_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, hn_q, hn_d, ln_q, ln_d, c_hi, c_lo;
  logic idle, acc, commit;
  md_calc u_calc (.a_i(A), .b_i(B), .op_i(MDOp[1:0]), .hi_o(c_hi), .lo_o(c_lo));
  always_comb begin
    idle = cnt_q == 4'd0;
    acc = Start && idle && !MDOp[2];
    commit = cnt_q == 4'd1;
    cnt_d = acc ? (MDOp[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES)) : (idle ? 4'd0 : cnt_q - 4'd1);
    hn_d = acc ? c_hi : hn_q;
    ln_d = acc ? c_lo : ln_q;
    hi_d = commit ? hn_q : (Start && idle && MDOp == MD_MTHI) ? A : hi_q;
    lo_d = commit ? ln_q : (Start && idle && MDOp == MD_MTLO) ? A : lo_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      hn_q <= '0;
      ln_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      hn_q <= hn_d;
      ln_q <= ln_d;
    end
  end
  assign Busy = |cnt_q;
  assign HI = hi_q;
  assign LO = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit
module tb_md_unit;
  import md_defs::*;
  logic clk = 1'b0, reset, Start, Busy;
  logic [31:0] A, B, HI, LO, hi_m, lo_m;
  logic [2:0] MDOp;
  logic [63:0] sb[$];
  int checks = 0, failures = 0;
  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp), .Start(Start),
    .Busy(Busy), .HI(HI), .LO(LO)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sbv = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint q, r, p;
    longint unsigned uq, ur, up;
    case (op)
      3'b000: begin p = sa * sbv; return p; end
      3'b001: begin up = ua * ub; return up; end
      3'b010: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction
  task automatic md_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int n, input int poke);
    logic [63:0] e;
    int cyc = 0;
    @(negedge clk);
    MDOp = op; A = a; B = b; Start = 1'b1;
    sb.push_back(model(op, a, b));
    @(posedge clk); #1;
    Start = 1'b0; A = ~a; B = b + 32'd1;
    check("busy_rise", Busy, 1);
    check("hold_hi", HI, hi_m);
    check("hold_lo", LO, lo_m);
    while (Busy && cyc < 20) begin
      if (cyc == poke) begin MDOp = MD_MTLO; A = 32'h1234; Start = 1'b1; end
      @(posedge clk); #1;
      Start = 1'b0;
      cyc++;
    end
    check("latency", cyc, n);
    e = sb.pop_front();
    hi_m = e[63:32];
    lo_m = e[31:0];
    check("hi", HI, hi_m);
    check("lo", LO, lo_m);
  endtask
  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    MDOp = op; A = a; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    if (op == MD_MTHI) hi_m = a;
    if (op == MD_MTLO) lo_m = a;
    check("mt_busy", Busy, 0);
    check("mt_hi", HI, hi_m);
    check("mt_lo", LO, lo_m);
  endtask
  initial begin
    logic [2:0] rop;
    reset = 1'b1; Start = 1'b0; A = '0; B = '0; MDOp = '0;
    hi_m = '0; lo_m = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", Busy, 0);
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    md_op(MD_MULT, 32'hFFFF_FFFF, 32'd2, 5, -1);
    check("mult_hi_const", HI, 32'hFFFF_FFFF);
    check("mult_lo_const", LO, 32'hFFFF_FFFE);
    md_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, -1);
    check("multu_hi_const", HI, 32'd1);
    md_op(MD_DIV, -32'sd7, 32'd2, 10, -1);
    check("div_lo_const", LO, 32'hFFFF_FFFD);
    check("div_hi_const", HI, 32'hFFFF_FFFF);
    md_op(MD_DIVU, 32'd7, 32'd2, 10, -1);
    md_op(MD_DIV, 32'd5, 32'd0, 10, -1);
    check("div0_lo_const", LO, 32'hFFFF_FFFF);
    md_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, -1);
    check("ovf_lo_const", LO, 32'h8000_0000);
    check("ovf_hi_const", HI, 32'd0);
    md_op(MD_DIVU, 32'hDEAD_BEEF, 32'd0, 10, -1);
    md_op(MD_MULT, 32'h0001_2345, 32'hFFFF_0F00, 5, 2);
    mt(MD_MTHI, 32'hABCD);
    mt(MD_MTLO, 32'h5555);
    mt(3'b110, 32'h7777);
    mt(3'b111, 32'h8888);
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 3));
      md_op(rop, $urandom, (i % 3 == 0) ? 32'd0 : $urandom, rop[1] ? 10 : 5, -1);
    end
    @(negedge clk);
    MDOp = MD_DIVU; A = 32'd7; B = 32'd2; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_busy", Busy, 0);
    check("midrst_hi", HI, 0);
    check("midrst_lo", LO, 0);
    repeat (8) @(posedge clk);
    #1;
    check("nocommit_busy", Busy, 0);
    check("nocommit_hi", HI, 0);
    check("nocommit_lo", LO, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
